// File: rtl/instr_fetch.sv
// LEGv8 instruction fetch: PC, single-outstanding imem request, prefetch FIFO, branch redirect.
// Optional macro FETCH_BYPASS_EN: forward a response straight to decode when the FIFO is empty.
module instr_fetch #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    input  logic        out_ready,
    input  logic        redirect,
    input  logic        redirect_uncond,
    input  logic [63:0] redirect_pc,
    input  logic [31:0] redirect_instr
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DROP} state_e;

    state_e             state_q, state_d;
    logic [63:0]        pc_q, pc_d;
    logic [63:0]        tag_q, tag_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [31:0]        instr_mem_q [DEPTH];
    logic [31:0]        instr_mem_d [DEPTH];
    logic [63:0]        pc_mem_q [DEPTH];
    logic [63:0]        pc_mem_d [DEPTH];

    logic               fire_c;
    logic               resp_c;
    logic               bypass_c;
    logic               push_c;
    logic               pop_c;
    logic [63:0]        imm_c;
    logic [63:0]        target_c;
    logic               unused_instr_c;

    assign unused_instr_c = ^redirect_instr[31:26];

    // Branch target: B uses imm26, CBZ uses imm19, both word offsets.
    always_comb begin
        imm_c = '0;
        if (redirect_uncond) begin
            imm_c = {{38{redirect_instr[25]}}, redirect_instr[25:0]};
        end else begin
            imm_c = {{45{redirect_instr[23]}}, redirect_instr[23:5]};
        end
        target_c = redirect_pc + (imm_c << 2);
    end

    assign imem_req  = (state_q == S_FETCH) && (count_q < CNT_W'(DEPTH)) && !redirect && !reset;
    assign imem_addr = pc_q;
    assign fire_c    = imem_req && imem_ready;
    assign resp_c    = (state_q == S_WAIT) && imem_rvalid;

`ifdef FETCH_BYPASS_EN
    assign bypass_c = resp_c && (count_q == '0) && !redirect;
`else
    assign bypass_c = 1'b0;
`endif

    assign out_valid = (count_q != '0) || bypass_c;
    assign out_instr = bypass_c ? imem_rdata : instr_mem_q[rd_q];
    assign out_pc    = bypass_c ? tag_q      : pc_mem_q[rd_q];
    assign pop_c     = (count_q != '0) && out_ready;
    assign push_c    = resp_c && !(bypass_c && out_ready);

    // Next-state: PC, tag, FIFO and fetch FSM.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tag_d       = tag_q;
        count_d     = count_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;

        case (state_q)
            S_FETCH: if (fire_c) state_d = S_WAIT;
            // A response landing in the redirect cycle is the outstanding one; nothing left to drop.
            S_WAIT:  if (imem_rvalid) state_d = S_FETCH;
                     else if (redirect) state_d = S_DROP;
            S_DROP:  if (imem_rvalid) state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase

        if (redirect) begin
            pc_d    = target_c;
            count_d = '0;
            rd_d    = '0;
            wr_d    = '0;
        end else begin
            if (fire_c) begin
                tag_d = pc_q;
                pc_d  = pc_q + 64'd4;
            end
            if (push_c) begin
                instr_mem_d[wr_q] = imem_rdata;
                pc_mem_d[wr_q]    = tag_q;
                wr_d = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            tag_q       <= '0;
            count_q     <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            instr_mem_q <= '{default: '0};
            pc_mem_q    <= '{default: '0};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tag_q       <= tag_d;
            count_q     <= count_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            instr_mem_q <= instr_mem_d;
            pc_mem_q    <= pc_mem_d;
        end
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 64-bit LEGv8 core. It owns the program counter and issues one request at a time to the instruction memory. Returned words go into a small prefetch FIFO, which hands `{pc, instr}` to the decode/control stage over a valid/ready handshake. It also computes B/CBZ branch targets, redirects the PC on a taken branch, flushes the FIFO and discards any in-flight response.

## Interface
- `DEPTH`, 2: prefetch FIFO entries (2..8).
- `RESET_PC`, 64'h0: PC value loaded by reset.

One clock; reset is synchronous and active-high.

- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 64: fetch address; always equals the current PC.
- `imem_ready` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: response word valid.
- `imem_rdata` in 32: response instruction word.
- `out_valid` out 1: FIFO head valid.
- `out_instr` out 32: instruction at the FIFO head.
- `out_pc` out 64: PC of the head instruction.
- `out_ready` in 1: decode consumes the head.
- `redirect` in 1: taken branch, sampled from decode.
- `redirect_uncond` in 1: 1 = B (imm26), 0 = CBZ (imm19).
- `redirect_pc` in 64: PC of the branch instruction.
- `redirect_instr` in 32: the branch instruction word.

## Operation
- Fetch FSM states:
  - FETCH: may issue a request.
  - WAIT: one request outstanding.
  - DROP: outstanding response is to be discarded.
- `imem_req` = (state==FETCH) && (count<DEPTH) && !redirect && !reset. It is combinational.
- Handshake: `imem_req && imem_ready`.
  - The request is tagged with the current PC.
  - PC <= PC+4 (mod 2^64).
  - State -> WAIT.
- WAIT + `imem_rvalid`:
  - Push `{tag_pc, imem_rdata}` into the FIFO.
  - State -> FETCH.
- DROP + `imem_rvalid`: discard the word; state -> FETCH.
- `imem_rvalid` in FETCH is ignored.
- Branch target:
  - `redirect_uncond`=1: imm = sext(`redirect_instr[25:0]`).
  - `redirect_uncond`=0: imm = sext(`redirect_instr[23:5]`).
  - target = `redirect_pc` + (imm<<2), 64-bit, wraps.
- `redirect`:
  - PC <= target.
  - FIFO count <= 0 (same-cycle pop and push are cancelled).
  - State: WAIT -> DROP; DROP stays DROP, unless `imem_rvalid` arrives that cycle, in which case -> FETCH; FETCH stays FETCH.
- FIFO:
  - Pop when `out_valid && out_ready`.
  - Push and pop in the same cycle leave count unchanged.
  - Overflow is impossible: a request is issued only when count<DEPTH.
  - Read/write pointers wrap modulo DEPTH.
- `out_valid` = (count != 0). `out_instr` and `out_pc` come from the head entry.
- Reset, regardless of state:
  - PC = RESET_PC.
  - count = 0.
  - state = FETCH.
  - A response outstanding at reset is not discarded. The memory must drop it.

## Timing
- Reset values:
  - `imem_req` = 0.
  - `imem_addr` = RESET_PC.
  - `out_valid` = 0.
  - `out_instr` = 0.
  - `out_pc` = 0.
- First `imem_req` in the first cycle after reset deasserts.
- Latency from `imem_rvalid` to `out_valid` is 1 cycle (registered FIFO).
- Minimum issue interval is 2 cycles: accept, then the response the next cycle.
- `redirect` suppresses `imem_req` in its own cycle. The new PC is requested from the following cycle.
- `out_valid`/`out_instr` stay stable while `out_ready`=0.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - When FETCH state... precisely: when `imem_rvalid` is high in WAIT with the FIFO empty, `out_valid`=1 and `{out_pc, out_instr}` = `{tag_pc, imem_rdata}` combinationally in the same cycle.
  - If `out_ready` is also high, the word is not stored.
  - `redirect` masks the bypass.
- `FETCH_BYPASS_EN` undefined: the 1-cycle registered path only.

## Test plan
- Reset with RESET_PC=64'h100, `imem_ready`=1, 1-cycle response, `out_ready`=1 -> requests at 0x100, 0x104, 0x108 every 2 cycles; `out_pc` follows the same sequence.
- Hold `out_ready`=0, DEPTH=2 -> exactly 2 words buffered; `imem_req` stays 0; releasing `out_ready` drains 0x100 then 0x104 and fetching resumes at 0x108.
- `redirect` with `redirect_uncond`=1, `redirect_pc`=0x200, imm26=-2 -> next request at 0x1F8; FIFO empty next cycle.
- `redirect` while in WAIT -> next `imem_rvalid` discarded (no `out_valid`); following request at the target.
- CBZ redirect, imm19=0x7FFFF, `redirect_pc`=0x0 -> target 0xFFFF_FFFF_FFFF_FFFC (wrap); `redirect` coinciding with a pop and a push -> count=0.
- With `FETCH_BYPASS_EN`, FIFO empty -> `out_valid` in the same cycle as `imem_rvalid`; `out_ready`=1 leaves count at 0.
